// File: rtl/softmax_q88_pkg.sv
// rtl/softmax_q88_pkg.sv - shared Q8.8 softmax widths, drain FSM encoding and sum width helper
package softmax_q88_pkg;

    localparam int Q88_W    = 16;
    localparam int Q88_FRAC = 8;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_RUN  = 1'b1
    } drain_state_t;

    // A VEC_LEN-term sum of DATA_W values needs log2(VEC_LEN) extra bits; stage 5 sizes its divider the same way
    function automatic int sum_width(input int data_w, input int vec_len);
        return data_w + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/pingpong_buf_2bank.sv
// rtl/pingpong_buf_2bank.sv - two-bank simple dual-port store with registered 1-cycle read
module pingpong_buf_2bank #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:2*DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_addr}] <= wr_data;
        if (rd_en)
            rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/stage4_pow2_sum_buffer.sv
// rtl/stage4_pow2_sum_buffer.sv - softmax stage 4: denominator accumulation and ping-pong vector replay
module stage4_pow2_sum_buffer
    import softmax_q88_pkg::*;
#(
    parameter int VEC_LEN = 64,
    parameter int DATA_W  = Q88_W,
    parameter int ADDR_W  = $clog2(VEC_LEN),
    parameter int SUM_W   = sum_width(DATA_W, VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pow_in_x,
    input  logic [DATA_W-1:0] in_x_bypass,
    output logic              valid_out,
    output logic [DATA_W-1:0] pow_out,
    output logic [DATA_W-1:0] in_x_out,
    output logic [SUM_W-1:0]  sum_out,
    output logic              first_out,
    output logic              last_out
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);

    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    frame_sum;
    logic [SUM_W-1:0]    pow_ext;
    logic [ADDR_W-1:0]   wr_idx;
    logic                wr_bank;
    logic                accept;
    logic                last_accept;

    drain_state_t        state;
    logic [ADDR_W-1:0]   rd_idx;
    logic                rd_bank;
    logic                rd_en;
    logic [2*DATA_W-1:0] rd_data;

    logic                s1_vld;
    logic                s1_first;
    logic                s1_last;
    logic [SUM_W-1:0]    s1_sum;

    assign pow_ext     = SUM_W'(pow_in_x);
    assign accept      = en && valid_in;
    assign last_accept = accept && (wr_idx == LAST_IDX);
    assign rd_en       = en && (state == DRAIN_RUN);

    pingpong_buf_2bank #(
        .DEPTH  (VEC_LEN),
        .WIDTH  (2*DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_bank (wr_bank),
        .wr_addr (wr_idx),
        .wr_data ({pow_in_x, in_x_bypass}),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // Fill side: wr_idx wraps by itself because VEC_LEN is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            frame_sum <= '0;
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
        end else if (accept) begin
            wr_idx <= wr_idx + 1'b1;
            if (last_accept) begin
                frame_sum <= acc + pow_ext;
                acc       <= '0;
                wr_bank   <= ~wr_bank;
            end else begin
                acc <= acc + pow_ext;
            end
        end
    end

    // Drain FSM; a handoff landing on the final read chains the next frame with no bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DRAIN_IDLE;
            rd_idx   <= '0;
            rd_bank  <= 1'b0;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else if (en) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (last_accept) begin
                        state   <= DRAIN_RUN;
                        rd_idx  <= '0;
                        rd_bank <= wr_bank;
                    end
                end
                DRAIN_RUN: begin
                    s1_vld   <= 1'b1;
                    s1_first <= (rd_idx == '0);
                    s1_last  <= (rd_idx == LAST_IDX);
                    s1_sum   <= frame_sum;
                    rd_idx   <= rd_idx + 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        if (last_accept)
                            rd_bank <= wr_bank;
                        else
                            state <= DRAIN_IDLE;
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            pow_out   <= '0;
            in_x_out  <= '0;
            sum_out   <= '0;
        end else if (en) begin
            valid_out <= s1_vld;
            first_out <= s1_first;
            last_out  <= s1_last;
            if (s1_vld) begin
                pow_out  <= rd_data[2*DATA_W-1:DATA_W];
                in_x_out <= rd_data[DATA_W-1:0];
                sum_out  <= s1_sum;
            end
        end
    end

endmodule

// File: tb/tb_stage4_pow2_sum_buffer.sv
// tb/tb_stage4_pow2_sum_buffer.sv - randomized self-checking bench with a frame-level reference model
module tb_stage4_pow2_sum_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] pow_in_x = '0;
    logic [15:0] in_x_bypass = '0;
    logic        valid_out, first_out, last_out;
    logic [15:0] pow_out, in_x_out;
    logic [17:0] sum_out;

    logic        v64 = 1'b0;
    logic [15:0] p64 = 16'hFFFF;
    logic        valid_out64, first_out64, last_out64;
    logic [15:0] pow_out64, in_x_out64;
    logic [21:0] sum_out64;

    always #5 clk = ~clk;

    stage4_pow2_sum_buffer #(.VEC_LEN(4)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .pow_in_x(pow_in_x), .in_x_bypass(in_x_bypass),
        .valid_out(valid_out), .pow_out(pow_out), .in_x_out(in_x_out),
        .sum_out(sum_out), .first_out(first_out), .last_out(last_out)
    );

    stage4_pow2_sum_buffer #(.VEC_LEN(64)) dut64 (
        .clk(clk), .rst(rst), .en(en), .valid_in(v64),
        .pow_in_x(p64), .in_x_bypass(16'h1234),
        .valid_out(valid_out64), .pow_out(pow_out64), .in_x_out(in_x_out64),
        .sum_out(sum_out64), .first_out(first_out64), .last_out(last_out64)
    );

    typedef struct {
        int          due;
        logic [15:0] p;
        logic [15:0] x;
        logic [17:0] s;
        bit          f;
        bit          l;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] fp[$];
    logic [15:0] fx[$];
    int          dcnt = 0;
    int          mcnt = 0;
    int          last_due = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // One enabled-edge-indexed cycle; a completed frame schedules its elements on the output timeline
    task automatic cyc(input bit e, input bit v, input logic [15:0] p, input logic [15:0] x);
        int s;
        int start;
        @(negedge clk);
        en = e; valid_in = v; pow_in_x = p; in_x_bypass = x;
        if (e) begin
            dcnt++;
            if (v) begin
                fp.push_back(p);
                fx.push_back(x);
                if (fp.size() == 4) begin
                    s = 0;
                    foreach (fp[i]) s += int'(fp[i]);
                    start = (dcnt + 2 > last_due + 1) ? dcnt + 2 : last_due + 1;
                    for (int i = 0; i < 4; i++)
                        expq.push_back('{due: start + i, p: fp[i], x: fx[i], s: 18'(s), f: (i == 0), l: (i == 3)});
                    last_due = start + 3;
                    fp.delete();
                    fx.delete();
                end
            end
        end
    endtask

    exp_t        ex;
    bit          e_s;
    logic        prev_v;
    logic [15:0] prev_p, prev_x;
    logic [17:0] prev_s;

    always begin
        @(posedge clk);
        e_s = en;
        #1;
        if (!rst) begin
            if (e_s) begin
                mcnt++;
                if (expq.size() > 0 && expq[0].due == mcnt) begin
                    ex = expq.pop_front();
                    check("valid", 32'(valid_out), 1);
                    check("pow", 32'(pow_out), 32'(ex.p));
                    check("x", 32'(in_x_out), 32'(ex.x));
                    check("sum", 32'(sum_out), 32'(ex.s));
                    check("first", 32'(first_out), 32'(ex.f));
                    check("last", 32'(last_out), 32'(ex.l));
                end else begin
                    check("valid_idle", 32'(valid_out), 0);
                end
            end else begin
                check("hold_valid", 32'(valid_out), 32'(prev_v));
                check("hold_pow", 32'(pow_out), 32'(prev_p));
                check("hold_x", 32'(in_x_out), 32'(prev_x));
                check("hold_sum", 32'(sum_out), 32'(prev_s));
            end
        end
        prev_v = valid_out; prev_p = pow_out; prev_x = in_x_out; prev_s = sum_out;
    end

    task automatic rand_frame(input bit gaps);
        for (int i = 0; i < 4; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) cyc(1'b0, 1'b1, 16'($urandom), 16'($urandom));
                else                           cyc(1'b1, 1'b0, 16'($urandom), 16'($urandom));
            end
            cyc(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    int first_j, nval, sum64, f64, l64;

    initial begin
        #12;
        check("rst_valid", 32'(valid_out), 0);
        check("rst_sum", 32'(sum_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // single frame with bypass pairing; sum 0x0200
        cyc(1, 1, 16'h0100, 16'h8000);
        cyc(1, 1, 16'h0080, 16'h8001);
        cyc(1, 1, 16'h0040, 16'h8002);
        cyc(1, 1, 16'h0040, 16'h8003);
        idle(6);

        // three back-to-back frames
        for (int f = 0; f < 3; f++) rand_frame(1'b0);
        idle(6);

        // gaps and stalls mid-fill and mid-drain
        cyc(1, 1, 16'h0011, 16'h0001);
        cyc(1, 0, 16'hDEAD, 16'hBEEF);
        cyc(1, 1, 16'h0022, 16'h0002);
        cyc(1, 0, 16'hDEAD, 16'hBEEF);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'hFFFF, 16'hFFFF);
        cyc(1, 1, 16'h0033, 16'h0003);
        cyc(1, 1, 16'h0044, 16'h0004);
        idle(3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 16'h0);
        idle(6);

        // randomized frames with gaps and stalls, some back-to-back
        for (int f = 0; f < 8; f++) rand_frame(f[0]);
        idle(8);

        // reset while element 1 is on the outputs
        cyc(1, 1, 16'h0101, 16'h7000);
        cyc(1, 1, 16'h0202, 16'h7001);
        cyc(1, 1, 16'h0303, 16'h7002);
        cyc(1, 1, 16'h0404, 16'h7003);
        idle(3);
        @(negedge clk);
        #2 rst = 1'b1; en = 1'b0; valid_in = 1'b0;
        #1;
        check("arst_valid", 32'(valid_out), 0);
        check("arst_first", 32'(first_out), 0);
        check("arst_last", 32'(last_out), 0);
        check("arst_pow", 32'(pow_out), 0);
        check("arst_x", 32'(in_x_out), 0);
        check("arst_sum", 32'(sum_out), 0);
        expq.delete(); fp.delete(); fx.delete();
        last_due = dcnt;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 1, 16'h1000, 16'h0A00);
        cyc(1, 1, 16'h2000, 16'h0A01);
        cyc(1, 1, 16'h3000, 16'h0A02);
        cyc(1, 1, 16'h4000, 16'h0A03);
        idle(8);

        // 64-element frame of 0xFFFF on the wide instance
        for (int i = 0; i < 64; i++) begin
            cyc(1, 0, 16'h0, 16'h0);
            v64 = 1'b1;
        end
        first_j = -1; nval = 0; sum64 = 0; f64 = 0; l64 = 0;
        for (int j = 0; j < 80; j++) begin
            cyc(1, 0, 16'h0, 16'h0);
            v64 = 1'b0;
            if (valid_out64) begin
                if (first_j < 0) begin
                    first_j = j;
                    sum64 = int'(sum_out64);
                    f64 = int'(first_out64);
                end
                nval++;
                if (nval == 64) l64 = int'(last_out64);
            end
        end
        check("max_latency", 32'(first_j), 2);
        check("max_sum", 32'(sum64), 32'h3FFFC0);
        check("max_count", 32'(nval), 64);
        check("max_first", 32'(f64), 1);
        check("max_last", 32'(l64), 1);

        for (int i = 0; i < 50 && expq.size() > 0; i++) idle(1);
        check("drain_done", 32'(expq.size()), 0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
